pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline controller for the five-stage core: it sequences the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers. It merges per-stage stall requests into a priority-encoded stall vector. It also owns the exception/eret redirect sequence: it freezes the pipe, waits out any in-flight data-memory access, then issues a one-cycle flush plus redirect PC. It sits beside the datapath, and every pipeline register and the PC register consume its outputs.

## Interface
Parameters:
- `EXC_VEC`, 32'h0000_0020: exception handler entry address.
- `CNT_W`, 32: width of the stall-cycle performance counter.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stallreq_id`  in  1  ID hazard (load-use).
- `stallreq_ex`  in  1  EX multi-cycle op busy (div/madd).
- `stallreq_mem`  in  1  data-memory access in flight.
- `excp_req`  in  1  exception or eret committed at MEM.
- `excp_is_eret`  in  1  qualifies `excp_req`: 1 = eret, 0 = exception.
- `cp0_epc`  in  32  return address for eret.
- `perf_clr`  in  1  synchronous clear of `stall_cycles`.
- `stall`  out  6  hold vector {wb,mem,ex,id,if,pc}; bit i = 1 holds stage i.
- `flush`  out  1  clear all pipeline registers to bubble.
- `new_pc`  out  32  redirect target, valid while `flush` = 1.
- `stall_cycles`  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Stall contract: a pipeline register between stage i and stage i+1 inserts a bubble when stall[i]=1 and stall[i+1]=0.
- FSM states: RUN, WAIT_MEM, FLUSH.
- RUN, excp_req=0: stall is combinational from requests, highest priority first:
  - stallreq_mem → 6'b011111.
  - stallreq_ex → 6'b001111.
  - stallreq_id → 6'b000111.
  - none → 6'b000000.
- RUN, excp_req=1:
  - stall=6'b111111 this cycle.
  - Latch target: cp0_epc if excp_is_eret, else EXC_VEC.
  - Next state WAIT_MEM if stallreq_mem=1, else FLUSH.
- WAIT_MEM:
  - stall=6'b111111.
  - excp_req ignored; latched target held.
  - Go to FLUSH on the first cycle stallreq_mem=0.
- FLUSH:
  - flush=1, stall=6'b000000, new_pc=latched target.
  - All requests ignored. Next state RUN unconditionally.
- flush and new_pc are registered, Moore outputs of state. new_pc holds its last value outside FLUSH.
- stall_cycles:
  - +1 on each cycle where state=RUN, excp_req=0 and stall≠0.
  - Saturates at all-ones.
  - perf_clr=1 → 0 next edge; clear wins over increment.

## Timing
- Reset (rst=0, asynchronous):
  - state=RUN, flush=0, new_pc=0, latched target=0, stall_cycles=0.
  - stall forced to 6'b000000 while rst=0.
- Stall latency: 0 cycles, combinational, same cycle as request.
- Exception, no memory busy: excp_req at cycle t → stall=111111 at t → flush=1 and new_pc valid at t+1 → RUN at t+2.
- Exception with memory busy: flush asserts the cycle after the first cycle with stallreq_mem=0 in WAIT_MEM.
- flush is exactly one cycle wide per accepted exception.
- Back-to-back: excp_req at t+1 (during FLUSH) is dropped. excp_req at t+2 starts a new sequence.
- Reset mid-sequence (WAIT_MEM or FLUSH): return to RUN immediately. No flush is issued after reset release.

## Structure
- Shared defines file holds:
  - Stall encodings `StallNone`, `StallId`, `StallEx`, `StallMem`, `StallAll`.
  - The state enum.
  - `ExcVecDefault`, reusing the existing `ZeroWord` / `InstAddrBus` definitions.
- One sub-module: `sat_counter` (CNT_W, inc, clr, q), reused later for other perf counters.
- Everything else is inline: FSM, target latch, stall encoder.

## Test plan
- Priority: stallreq_id=1, stallreq_ex=1, then stallreq_mem=1 added → stall 6'b001111, then 6'b011111. stall_cycles increments by 1 per stalled cycle.
- Exception, memory idle: excp_req=1, excp_is_eret=0 at cycle t → stall=6'b111111 at t; flush=1, new_pc=32'h0000_0020 at t+1; flush=0 at t+2.
- eret with memory busy: cp0_epc=32'h0000_1234, stallreq_mem high for 3 cycles → stall=6'b111111 for 3 cycles (WAIT_MEM). flush asserts one cycle after stallreq_mem drops, with new_pc=32'h0000_1234; cp0_epc changes after t are ignored.
- Dropped request: second excp_req during FLUSH → no second flush pulse.
- Counter: preset stall_cycles near all-ones, hold stallreq_id=1 → sticks at 2^CNT_W−1. perf_clr=1 together with a stall → 0.
- Reset: assert rst=0 during WAIT_MEM → all outputs at reset values immediately. After release, stall follows requests and flush stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: bus widths, stall encodings
// and the redirect-sequencer state enum.
package pipe_ctrl_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam logic [InstAddrBus-1:0] ZeroWord      = '0;
  localparam logic [InstAddrBus-1:0] ExcVecDefault = 32'h0000_0020;

  // Stall vector bit order is {wb,mem,ex,id,if,pc}
  localparam int unsigned StallW = 6;
  localparam logic [StallW-1:0] StallNone = 6'b000000;
  localparam logic [StallW-1:0] StallId   = 6'b000111;
  localparam logic [StallW-1:0] StallEx   = 6'b001111;
  localparam logic [StallW-1:0] StallMem  = 6'b011111;
  localparam logic [StallW-1:0] StallAll  = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: priority stall encoder, exception/eret redirect
// sequencer (freeze, drain data memory, one-cycle flush) and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] EXC_VEC = ExcVecDefault,
  parameter int unsigned            CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic                   excp_req,
  input  logic                   excp_is_eret,
  input  logic [InstAddrBus-1:0] cp0_epc,
  input  logic                   perf_clr,
  output logic [StallW-1:0]      stall,
  output logic                   flush,
  output logic [InstAddrBus-1:0] new_pc,
  output logic [CNT_W-1:0]       stall_cycles
);

  ctrl_state_e            r_state;
  logic                   r_flush;
  logic [InstAddrBus-1:0] r_new_pc;
  logic [InstAddrBus-1:0] r_target;

  ctrl_state_e            w_state_nxt;
  logic [InstAddrBus-1:0] w_target_nxt;
  logic [StallW-1:0]      w_stall;
  logic                   w_cnt_inc;

  // Stall encoder: zero-latency from requests, overridden while redirecting
  always_comb begin
    w_stall = StallNone;
    if (rst) begin
      unique case (r_state)
        ST_RUN: begin
          if (excp_req)          w_stall = StallAll;
          else if (stallreq_mem) w_stall = StallMem;
          else if (stallreq_ex)  w_stall = StallEx;
          else if (stallreq_id)  w_stall = StallId;
          else                   w_stall = StallNone;
        end
        ST_WAIT_MEM: w_stall = StallAll;
        ST_FLUSH:    w_stall = StallNone;
        default:     w_stall = StallNone;
      endcase
    end
  end

  // Redirect sequencer next state and target capture
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    unique case (r_state)
      ST_RUN: begin
        if (excp_req) begin
          w_target_nxt = excp_is_eret ? cp0_epc : EXC_VEC;
          w_state_nxt  = stallreq_mem ? ST_WAIT_MEM : ST_FLUSH;
        end
      end
      ST_WAIT_MEM: begin
        if (!stallreq_mem) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // flush/new_pc are registered from the next state so they line up with FLUSH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= ZeroWord;
      r_target <= ZeroWord;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_flush  <= (w_state_nxt == ST_FLUSH);
      if (w_state_nxt == ST_FLUSH) r_new_pc <= w_target_nxt;
    end
  end

  // Only hazard stalls count; exception freezes do not
  assign w_cnt_inc = (r_state == ST_RUN) && !excp_req && (w_stall != StallNone);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (w_cnt_inc),
    .clr   (perf_clr),
    .q     (stall_cycles)
  );

  assign stall  = w_stall;
  assign flush  = r_flush;
  assign new_pc = r_new_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_id, stallreq_ex, stallreq_mem;
  logic          excp_req, excp_is_eret, perf_clr;
  logic [31:0]   cp0_epc;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic [CW-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Model: an exception sequence is "draining" until memory is idle, then one flush cycle
  bit          m_draining;
  bit          m_flushing;
  logic [31:0] m_target;
  logic [31:0] m_new_pc;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VEC (32'h0000_0020),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_req     (excp_req),
    .excp_is_eret (excp_is_eret),
    .cp0_epc      (cp0_epc),
    .perf_clr     (perf_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cycles (stall_cycles)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_stall();
    if (m_flushing) return 6'b000000;
    if (m_draining || excp_req) return 6'b111111;
    if (stallreq_mem) return 6'b011111;
    if (stallreq_ex)  return 6'b001111;
    if (stallreq_id)  return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_draining = 1'b0;
    m_flushing = 1'b0;
    m_target   = 32'h0;
    m_new_pc   = 32'h0;
    m_cnt      = 0;
  endtask

  task automatic set_in(input bit id, input bit ex, input bit mem, input bit exc,
                        input bit eret, input logic [31:0] epc, input bit clr);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excp_req     = exc;
    excp_is_eret = eret;
    cp0_epc      = epc;
    perf_clr     = clr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_stall"}, 32'(stall), 32'h0);
    check_val({tag, "_flush"}, 32'(flush), 32'h0);
    check_val({tag, "_new_pc"}, new_pc, 32'h0);
    check_val({tag, "_cnt"}, 32'(stall_cycles), 32'h0);
  endtask

  // One clock: check outputs against the model, then advance the model at the edge
  task automatic cycle(input string tag);
    logic [5:0] exp_stall;
    bit         counts;
    #1;
    exp_stall = model_stall();
    check_val({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check_val({tag, "_flush"}, 32'(flush), 32'(m_flushing));
    check_val({tag, "_new_pc"}, new_pc, m_new_pc);
    check_val({tag, "_cnt"}, 32'(stall_cycles), m_cnt);
    counts = !m_flushing && !m_draining && !excp_req && (exp_stall != 6'b0);
    @(posedge clk);
    if (perf_clr) m_cnt = 0;
    else if (counts && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    if (m_flushing) begin
      m_flushing = 1'b0;
    end else if (m_draining) begin
      if (!stallreq_mem) begin
        m_draining = 1'b0;
        m_flushing = 1'b1;
        m_new_pc   = m_target;
      end
    end else if (excp_req) begin
      m_target = excp_is_eret ? cp0_epc : 32'h0000_0020;
      if (stallreq_mem) m_draining = 1'b1;
      else begin
        m_flushing = 1'b1;
        m_new_pc   = m_target;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0, 0);
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Priority ladder
    set_in(1, 0, 0, 0, 0, 32'h0, 0); cycle("prio_id");
    set_in(1, 1, 0, 0, 0, 32'h0, 0); cycle("prio_ex");
    #1 check_val("prio_ex_code", 32'(stall), 32'h0000_000f);
    set_in(1, 1, 1, 0, 0, 32'h0, 0); cycle("prio_mem");
    #1 check_val("prio_mem_code", 32'(stall), 32'h0000_001f);
    set_in(0, 0, 0, 0, 0, 32'h0, 0); cycle("prio_idle");

    // Exception with memory idle
    set_in(0, 0, 0, 1, 0, 32'h0, 0); cycle("exc_t0");
    set_in(0, 0, 0, 0, 0, 32'h0, 0);
    #1 check_val("exc_flush_t1", 32'(flush), 32'h1);
    check_val("exc_pc_t1", new_pc, 32'h0000_0020);
    cycle("exc_t1"); cycle("exc_t2");

    // eret with memory busy; later epc changes are ignored
    set_in(0, 0, 1, 1, 1, 32'h0000_1234, 0); cycle("eret_t0");
    set_in(0, 0, 1, 0, 0, 32'h0000_5555, 0); cycle("eret_w1"); cycle("eret_w2");
    set_in(0, 0, 0, 0, 0, 32'h0000_7777, 0); cycle("eret_w3");
    #1 check_val("eret_pc", new_pc, 32'h0000_1234);
    cycle("eret_fl"); cycle("eret_run");

    // Request during FLUSH is dropped
    set_in(0, 0, 0, 1, 0, 32'h0, 0); cycle("drop_t0"); cycle("drop_t1");
    set_in(0, 0, 0, 0, 0, 32'h0, 0); cycle("drop_t2"); cycle("drop_t3");

    // Counter saturation, then clear beside a stall
    set_in(1, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 20; i++) cycle("sat");
    #1 check_val("sat_max", 32'(stall_cycles), CNT_MAX);
    set_in(1, 0, 0, 0, 0, 32'h0, 1); cycle("clr");
    set_in(0, 0, 0, 0, 0, 32'h0, 0); cycle("clr_after");

    // Reset during WAIT_MEM
    set_in(0, 0, 1, 1, 0, 32'h0, 0); cycle("rst_t0");
    set_in(0, 0, 1, 0, 0, 32'h0, 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 32'h0, 0); cycle("post_rst_id");
    set_in(0, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cycle("post_rst_idle");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 1),
             1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 39) == 0));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
